// File: rtl/l2_cache_control_pkg.sv
// Shared types for the L2 cache controller: FSM state encoding and default counter width.
package l2_types;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;
endpackage

// File: rtl/l2_cache_control_if.sv
// Upstream request, datapath status/strobe and physical-memory handshake bundle.
// master = requester/datapath/memory side, slave = the controller.
interface l2_cache_control_if;
  logic       mem_read, mem_write, mem_resp;
  logic       hit, hit_way, lru, victim_dirty;
  logic [1:0] load_data, load_tag, load_valid, load_dirty;
  logic       dirty_in, load_lru, lru_in, data_sel, addr_sel;
  logic       pmem_read, pmem_write, pmem_resp;

  modport master (
    output mem_read, mem_write, hit, hit_way, lru, victim_dirty, pmem_resp,
    input  mem_resp, load_data, load_tag, load_valid, load_dirty,
           dirty_in, load_lru, lru_in, data_sel, addr_sel, pmem_read, pmem_write
  );
  modport slave (
    input  mem_read, mem_write, hit, hit_way, lru, victim_dirty, pmem_resp,
    output mem_resp, load_data, load_tag, load_valid, load_dirty,
           dirty_in, load_lru, lru_in, data_sel, addr_sel, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module l2_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     count <= '0;
        else if (clr)                count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/l2_cache_control.sv
// Two-way L2 cache controller FSM: hit service, dirty-victim writeback, line refill,
// and hit/miss performance counters. Array strobes are decoded from state and inputs.
module l2_cache_control
    import l2_types::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    l2_cache_control_if.slave bus,
    input  logic             ctr_clr,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    state_e state;
    logic   refill;
    logic   is_write;
    logic   mem_resp_c;

    assign is_write = bus.mem_write;

    always_comb begin
        mem_resp_c     = 1'b0;
        bus.load_data  = 2'b00;
        bus.load_tag   = 2'b00;
        bus.load_valid = 2'b00;
        bus.load_dirty = 2'b00;
        bus.dirty_in   = 1'b0;
        bus.load_lru   = 1'b0;
        bus.lru_in     = 1'b0;
        bus.data_sel   = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        case (state)
            COMPARE: begin
                if (bus.hit) begin
                    mem_resp_c   = 1'b1;
                    bus.load_lru = 1'b1;
                    bus.lru_in   = ~bus.hit_way;
                    if (is_write) begin
                        bus.load_data[bus.hit_way]  = 1'b1;
                        bus.load_dirty[bus.hit_way] = 1'b1;
                        bus.dirty_in                = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.addr_sel   = 1'b1;
            end
            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.load_data[bus.lru]  = 1'b1;
                    bus.load_tag[bus.lru]   = 1'b1;
                    bus.load_valid[bus.lru] = 1'b1;
                    bus.load_dirty[bus.lru] = 1'b1;
                    bus.data_sel            = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_resp = mem_resp_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            refill <= 1'b0;
        end else begin
            case (state)
                IDLE:      if (bus.mem_read || bus.mem_write) state <= COMPARE;
                COMPARE:   if (bus.hit) state <= IDLE;
                           else state <= bus.victim_dirty ? WRITEBACK : ALLOCATE;
                WRITEBACK: if (bus.pmem_resp) state <= ALLOCATE;
                ALLOCATE:  if (bus.pmem_resp) state <= COMPARE;
                default:   state <= IDLE;
            endcase
            // The hit that completes a refill is not a true hit; remember it across the loop back.
            if (state == ALLOCATE && bus.pmem_resp) refill <= 1'b1;
            else if (mem_resp_c)                    refill <= 1'b0;
        end
    end

    logic hit_inc, miss_inc;
    assign hit_inc  = (state == COMPARE) &&  bus.hit && !refill;
    assign miss_inc = (state == COMPARE) && !bus.hit;

    l2_sat_counter #(.CNT_W(CNT_W)) u_hit_ctr (
        .clk(clk), .rst(rst), .inc(hit_inc), .clr(ctr_clr), .count(hit_count)
    );
    l2_sat_counter #(.CNT_W(CNT_W)) u_miss_ctr (
        .clk(clk), .rst(rst), .inc(miss_inc), .clr(ctr_clr), .count(miss_count)
    );
endmodule

// File: tb/tb_l2_cache_control.sv
// Self-checking bench: transaction-level model of the controller's protocol and counters.
module tb_l2_cache_control;
    localparam int CW  = 2;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctr_clr = 1'b0;
    logic [CW-1:0] hit_count, miss_count;
    int            tests = 0, fails = 0;
    int            hits = 0, misses = 0;

    l2_cache_control_if bus();

    l2_cache_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ctr_clr(ctr_clr),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int raw);
        return (raw > MAX) ? MAX : raw;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_pmem"}, {bus.pmem_read, bus.pmem_write}, 0);
        chk({tag, "_strb"}, {bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty, bus.load_lru}, 0);
        chk({tag, "_resp"}, bus.mem_resp, 0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_hitc"}, hit_count, sat(hits));
        chk({tag, "_missc"}, miss_count, sat(misses));
    endtask

    // One upstream request; on a miss the model plays memory with the given latencies.
    task automatic txn(input bit wr, input bit both, input bit hit0, input bit way, input bit lr,
                       input bit vd, input int wbd, input int ald, input bit clr_cmp);
        logic [1:0] wmask;
        @(posedge clk); #1;
        bus.mem_write = wr; bus.mem_read = !wr || both;
        bus.hit = hit0; bus.hit_way = way; bus.lru = lr; bus.victim_dirty = vd;
        @(negedge clk);
        chk_quiet("idle");
        @(posedge clk); #1;
        ctr_clr = clr_cmp;
        @(negedge clk);
        if (hit0) begin
            wmask = wr ? (2'b01 << way) : 2'b00;
            chk("hit_resp", bus.mem_resp, 1);
            chk("hit_lru", {bus.load_lru, bus.lru_in}, {1'b1, ~way});
            chk("hit_data", {bus.load_data, bus.load_dirty}, {wmask, wmask});
            chk("hit_misc", {bus.dirty_in, bus.data_sel, bus.load_tag, bus.load_valid}, {wr, 1'b0, 4'b0});
        end else begin
            chk_quiet("miss");
        end
        if (clr_cmp) begin hits = 0; misses = 0; end
        else if (hit0) hits++;
        else misses++;
        @(posedge clk); #1;
        ctr_clr = 1'b0;
        if (!hit0) begin
            if (vd) for (int k = 0; k < wbd; k++) begin
                bus.pmem_resp = (k == wbd - 1);
                @(negedge clk);
                chk("wb_pmem", {bus.pmem_write, bus.pmem_read, bus.addr_sel}, 3'b101);
                chk("wb_strb", {bus.load_data, bus.load_tag, bus.mem_resp}, 0);
                @(posedge clk); #1;
            end
            for (int k = 0; k < ald; k++) begin
                bus.pmem_resp = (k == ald - 1);
                @(negedge clk);
                chk("al_pmem", {bus.pmem_write, bus.pmem_read, bus.addr_sel}, 3'b010);
                wmask = (k == ald - 1) ? (2'b01 << lr) : 2'b00;
                chk("al_load", {bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty},
                    {wmask, wmask, wmask, wmask});
                chk("al_sel", {bus.data_sel, bus.dirty_in, bus.mem_resp}, {(k == ald - 1), 2'b00});
                @(posedge clk); #1;
            end
            bus.pmem_resp = 1'b0;
            bus.hit = 1'b1; bus.hit_way = lr;
            @(negedge clk);
            wmask = wr ? (2'b01 << lr) : 2'b00;
            chk("rf_resp", {bus.mem_resp, bus.load_lru, bus.lru_in}, {2'b11, ~lr});
            chk("rf_data", {bus.load_data, bus.load_dirty, bus.pmem_read}, {wmask, wmask, 1'b0});
            @(posedge clk); #1;
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit = 1'b0;
        @(negedge clk);
        chk_counts("post");
        chk("post_resp", bus.mem_resp, 0);
    endtask

    initial begin
        bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0; bus.hit_way = 0;
        bus.lru = 0; bus.victim_dirty = 0; bus.pmem_resp = 0;
        #12;
        chk_quiet("rst");
        chk_counts("rst");
        @(posedge clk); #1 rst = 1'b0;

        // read hit way1; write hit way0; clean miss lru=1 (5-cycle memory); dirty miss with both strobes
        txn(0, 0, 1, 1, 0, 0, 1, 1, 0);
        txn(1, 0, 1, 0, 0, 0, 1, 1, 0);
        txn(0, 0, 0, 0, 1, 0, 1, 5, 0);
        txn(1, 1, 0, 0, 0, 1, 3, 2, 0);

        // saturation: four more hits push hit_count to the ceiling; clear coinciding with a hit wins
        for (int i = 0; i < 4; i++) txn(0, 0, 1, i[0], 0, 0, 1, 1, 0);
        txn(0, 0, 1, 0, 0, 0, 1, 1, 1);

        // reset in the middle of a refill
        @(posedge clk); #1;
        bus.mem_read = 1; bus.hit = 0; bus.victim_dirty = 0; bus.lru = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_pread", bus.pmem_read, 1);
        #1 rst = 1'b1;
        #1;
        chk_quiet("midrst");
        hits = 0; misses = 0;
        chk_counts("midrst");
        bus.mem_read = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("after_rst");
        txn(0, 0, 1, 0, 0, 0, 1, 1, 0);

        // randomized traffic with stray memory responses and idle clears
        for (int i = 0; i < 40; i++) begin
            bit wr, hh;
            wr = $urandom_range(0, 1);
            hh = $urandom_range(0, 1);
            txn(wr, wr & $urandom_range(0, 1), hh, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(1, 4), $urandom_range(1, 4),
                ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1 bus.pmem_resp = 1'b1;
                @(negedge clk);
                chk_quiet("stray");
                @(posedge clk); #1 bus.pmem_resp = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #1 ctr_clr = 1'b1;
                @(posedge clk); #1 ctr_clr = 1'b0;
                hits = 0; misses = 0;
                @(negedge clk);
                chk_counts("idle_clr");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/l2_cache_control.md
L2_CACHE_CONTROL -- requirements
Module: l2_cache_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of each performance counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port mem_read  in  1  upstream read request; held until mem_resp.
REQ-005 SHALL have port mem_write  in  1  upstream write request; held until mem_resp.
REQ-006 SHALL have port mem_resp  out  1  one-cycle request-complete pulse.
REQ-007 SHALL have port hit  in  1  datapath tag match, either way, indexed set.
REQ-008 SHALL have port hit_way  in  1  way that matched; valid only when hit=1.
REQ-009 SHALL have port lru  in  1  LRU way of the indexed set; this is the victim way.
REQ-010 SHALL have port victim_dirty  in  1  victim way is valid and dirty.
REQ-011 SHALL have port load_data, load_tag, load_valid, load_dirty  out  2 each  per-way array write strobes.
REQ-012 SHALL have port dirty_in  out  1  value written on a load_dirty strobe.
REQ-013 SHALL have port load_lru, lru_in  out  1 each  LRU array write strobe and value.
REQ-014 SHALL have port data_sel  out  1  0 = upstream write data, 1 = pmem line.
REQ-015 SHALL have port addr_sel  out  1  0 = request address, 1 = victim tag+index.
REQ-016 SHALL have port pmem_read, pmem_write  out  1 each  memory requests; held until pmem_resp.
REQ-017 SHALL have port pmem_resp  in  1  memory completion pulse.
REQ-018 SHALL have port ctr_clr  in  1  synchronous clear of both counters.
REQ-019 SHALL have port hit_count, miss_count  out  CNT_W each  saturating performance counters.

Function
REQ-020 SHALL implement states IDLE, COMPARE, WRITEBACK, ALLOCATE; all outputs decoded from state and inputs, 0 unless stated.
REQ-021 IDLE: mem_read|mem_write -> COMPARE next cycle; else stay.
REQ-022 COMPARE with hit: mem_resp=1, load_lru=1, lru_in=~hit_way; on write also load_data[hit_way]=1, load_dirty[hit_way]=1, dirty_in=1, data_sel=0; -> IDLE.
REQ-023 COMPARE with miss: -> WRITEBACK if victim_dirty, else ALLOCATE; no array strobes.
REQ-024 WRITEBACK: pmem_write=1, addr_sel=1; on pmem_resp -> ALLOCATE.
REQ-025 ALLOCATE: pmem_read=1, addr_sel=0; on pmem_resp assert load_data, load_tag, load_valid, load_dirty for way lru, dirty_in=0, data_sel=1; -> COMPARE.
REQ-026 Hit latency SHALL be exactly 2 cycles from request assertion in IDLE to mem_resp; clean miss adds ALLOCATE duration plus one COMPARE cycle.
REQ-027 mem_read and mem_write both high SHALL be treated as a write.
REQ-028 pmem_resp outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-029 A registered refill flag SHALL be set leaving ALLOCATE and cleared on mem_resp; COMPARE hit with refill=0 increments hit_count, COMPARE miss increments miss_count, refill hit increments neither.
REQ-030 Counters SHALL saturate at 2^CNT_W-1; ctr_clr coincident with an increment SHALL clear (clear wins).

Reset
REQ-031 rst SHALL asynchronously force IDLE, refill=0, hit_count=0, miss_count=0; all strobes and mem_resp 0 while rst is high.
REQ-032 Reset mid-WRITEBACK/ALLOCATE SHALL drop pmem_read/pmem_write immediately; no array strobe SHALL issue.

Structure
REQ-033 Package l2_types SHALL hold the state enum and default CNT_W constant.
REQ-034 Counters SHALL use one sub-module l2_sat_counter (inc, clr, count; parameter CNT_W), instantiated twice.

Verification
REQ-035 Read hit: mem_read=1, hit=1, hit_way=1 -> mem_resp at cycle 2, load_lru=1, lru_in=0, hit_count=1.
REQ-036 Write hit way 0 -> load_data=2'b01, load_dirty=2'b01, dirty_in=1, data_sel=0, mem_resp once.
REQ-037 Clean read miss, lru=1, pmem_resp after 5 cycles -> pmem_read held 5 cycles, load_tag=2'b10, then COMPARE hit, miss_count=1, hit_count=0.
REQ-038 Dirty miss -> pmem_write with addr_sel=1 until pmem_resp, then pmem_read, then mem_resp; no overlap of pmem_read/pmem_write.
REQ-039 rst pulsed mid-ALLOCATE -> pmem_read=0 same cycle, state IDLE, counters 0.
REQ-040 CNT_W=2, 4 hits -> hit_count stays 3; ctr_clr with hit -> 0.
